// File: rtl/ucsbece154a_mc_controller.sv
// Multicycle RV32I main controller: Moore FSM sequencing the shared ALU/memory datapath,
// with the ALU decoder and immediate-select decoder folded in.
module ucsbece154a_mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       Error,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_LUI      = 4'd11,
    S_ERROR    = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       taken;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d = S_ERROR;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BRANCH:    state_d = S_BRANCH;
          OP_LUI:       state_d = S_LUI;
          default:      state_d = S_ERROR;
        endcase
      end
      // op[5] separates sw (store) from lw (load) among the memory opcodes
      S_MEMADR:                          state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:                         state_d = S_MEMWB;
      S_EXECUTER, S_EXECUTEI, S_JAL:     state_d = S_ALUWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB,
      S_BRANCH, S_LUI:                   state_d = S_FETCH;
      default:                           state_d = S_ERROR;
    endcase
  end

  always_comb begin
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    pc_update = 1'b0;
    branch    = 1'b0;
    Error     = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      S_LUI: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
      end
      S_ERROR:    Error = 1'b1;
      default:    Error = 1'b1;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      default: taken = 1'b0;
    endcase
  end

  assign PCWrite = pc_update | (branch & taken);

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_LW, OP_ITYPE: ImmSrc = 3'b000;
      OP_SW:           ImmSrc = 3'b001;
      OP_BRANCH:       ImmSrc = 3'b010;
      OP_JAL:          ImmSrc = 3'b011;
      OP_LUI:          ImmSrc = 3'b100;
      default:         ImmSrc = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_ucsbece154a_mc_controller.sv
// Self-checking bench for the multicycle controller: per-instruction cycle model built
// from instruction classes, with randomized instruction mix, funct fields and zero flag.
module tb_ucsbece154a_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Error;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  localparam int C_LW  = 0;
  localparam int C_SW  = 1;
  localparam int C_R   = 2;
  localparam int C_I   = 3;
  localparam int C_JAL = 4;
  localparam int C_BR  = 5;
  localparam int C_LUI = 6;

  ucsbece154a_mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .Error(Error), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] op_of(input int cls);
    case (cls)
      C_LW:    return 7'b0000011;
      C_SW:    return 7'b0100011;
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_JAL:   return 7'b1101111;
      C_BR:    return 7'b1100011;
      default: return 7'b0110111;
    endcase
  endfunction

  // Runs one instruction from FETCH; entry and exit are just after a rising edge.
  task automatic run_instr(input int cls, input logic [2:0] f3, input logic f7);
    logic [3:0] seq[$];
    logic [3:0] e_state;
    logic       e_rw, e_mw, e_pcw, e_irw, e_adr;
    logic [1:0] e_res;
    logic [2:0] e_alu, e_imm;
    logic [3:0] e_src;
    int         last;
    case (cls)
      C_LW:    seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      C_SW:    seq = '{4'd0, 4'd1, 4'd2, 4'd5};
      C_R:     seq = '{4'd0, 4'd1, 4'd6, 4'd7};
      C_I:     seq = '{4'd0, 4'd1, 4'd8, 4'd7};
      C_JAL:   seq = '{4'd0, 4'd1, 4'd9, 4'd7};
      C_BR:    seq = '{4'd0, 4'd1, 4'd10};
      default: seq = '{4'd0, 4'd1, 4'd11};
    endcase
    last     = seq.size() - 1;
    op       = op_of(cls);
    funct3   = f3;
    funct7b5 = f7;
    case (cls)
      C_SW:    e_imm = 3'b001;
      C_BR:    e_imm = 3'b010;
      C_JAL:   e_imm = 3'b011;
      C_LUI:   e_imm = 3'b100;
      default: e_imm = 3'b000;
    endcase
    for (int k = 0; k <= last; k++) begin
      zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      e_state = seq[k];
      e_rw  = (k == last) && (cls != C_SW) && (cls != C_BR);
      e_mw  = (k == last) && (cls == C_SW);
      e_irw = (k == 0);
      e_pcw = (k == 0) || (cls == C_JAL && k == 2) ||
              (cls == C_BR && k == 2 && ((f3 == 3'b000 && zero) || (f3 == 3'b001 && !zero)));
      e_adr = (k == 3) && (cls == C_LW || cls == C_SW);
      if (k == 0)                      e_res = 2'b10;
      else if (cls == C_LUI && k == 2) e_res = 2'b11;
      else if (cls == C_LW && k == 4)  e_res = 2'b01;
      else                             e_res = 2'b00;
      e_alu = 3'b000;
      if (cls == C_BR && k == 2) e_alu = 3'b001;
      if ((cls == C_R || cls == C_I) && k == 2)
        case (f3)
          3'b000:  e_alu = (cls == C_R && f7) ? 3'b001 : 3'b000;
          3'b010:  e_alu = 3'b101;
          3'b110:  e_alu = 3'b011;
          3'b111:  e_alu = 3'b010;
          default: e_alu = 3'b000;
        endcase
      // {ALUSrcA, ALUSrcB}: PC+4, OldPC+imm, then the operands of the class's ALU cycle
      if (k == 0)      e_src = 4'b0010;
      else if (k == 1) e_src = 4'b0101;
      else if (k == 2)
        case (cls)
          C_LW, C_SW, C_I: e_src = 4'b1001;
          C_R, C_BR:       e_src = 4'b1000;
          C_JAL:           e_src = 4'b0110;
          default:         e_src = 4'b0000;
        endcase
      else e_src = 4'b0000;

      checks += 10;
      if (state !== e_state) begin errors++;
        $display("FAIL state cls=%0d k=%0d got %0d want %0d", cls, k, state, e_state); end
      if (RegWrite !== e_rw) begin errors++;
        $display("FAIL RegWrite cls=%0d k=%0d got %b want %b", cls, k, RegWrite, e_rw); end
      if (MemWrite !== e_mw) begin errors++;
        $display("FAIL MemWrite cls=%0d k=%0d got %b want %b", cls, k, MemWrite, e_mw); end
      if (PCWrite !== e_pcw) begin errors++;
        $display("FAIL PCWrite cls=%0d k=%0d f3=%0d zero=%b got %b want %b", cls, k, f3, zero, PCWrite, e_pcw); end
      if (IRWrite !== e_irw) begin errors++;
        $display("FAIL IRWrite cls=%0d k=%0d got %b want %b", cls, k, IRWrite, e_irw); end
      if (AdrSrc !== e_adr) begin errors++;
        $display("FAIL AdrSrc cls=%0d k=%0d got %b want %b", cls, k, AdrSrc, e_adr); end
      if (ResultSrc !== e_res) begin errors++;
        $display("FAIL ResultSrc cls=%0d k=%0d got %b want %b", cls, k, ResultSrc, e_res); end
      if (ALUControl !== e_alu) begin errors++;
        $display("FAIL ALUControl cls=%0d k=%0d f3=%0d f7=%b got %b want %b", cls, k, f3, f7, ALUControl, e_alu); end
      if (ImmSrc !== e_imm) begin errors++;
        $display("FAIL ImmSrc cls=%0d k=%0d got %b want %b", cls, k, ImmSrc, e_imm); end
      if ({ALUSrcA, ALUSrcB, Error} !== {e_src, 1'b0}) begin errors++;
        $display("FAIL srcs_error cls=%0d k=%0d got %b want %b", cls, k, {ALUSrcA, ALUSrcB, Error}, {e_src, 1'b0}); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0; reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    if (IRWrite !== 1'b1) begin errors++; $display("FAIL reset_irwrite got %b want 1", IRWrite); end
    if (PCWrite !== 1'b1) begin errors++; $display("FAIL reset_pcwrite got %b want 1", PCWrite); end
    if (ALUSrcB !== 2'b10) begin errors++; $display("FAIL reset_alusrcb got %b want 10", ALUSrcB); end
    if (Error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", Error); end
    reset = 1'b0;
  endtask

  task automatic test_lw();
    run_instr(C_LW, 3'b010, 1'b0);
  endtask

  task automatic test_rtype();
    run_instr(C_R, 3'b000, 1'b1);
    run_instr(C_R, 3'b000, 1'b0);
    run_instr(C_R, 3'b111, 1'b0);
    run_instr(C_I, 3'b000, 1'b1);
  endtask

  task automatic test_branch();
    for (int i = 0; i < 8; i++) run_instr(C_BR, (i % 2 == 0) ? 3'b000 : 3'b001, 1'b0);
    run_instr(C_BR, 3'b100, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_instr(C_SW, 3'b010, 1'b0);
    run_instr(C_LUI, 3'b000, 1'b0);
    run_instr(C_JAL, 3'b000, 1'b0);
  endtask

  task automatic test_illegal();
    op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks += 2;
      if (state !== 4'd15 || Error !== 1'b1) begin errors++;
        $display("FAIL illegal_hold cyc=%0d got state=%0d err=%b want 15/1", i, state, Error); end
      if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin errors++;
        $display("FAIL illegal_enables cyc=%0d got %b want 0000", i, {PCWrite, IRWrite, RegWrite, MemWrite}); end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (state !== 4'd0 || Error !== 1'b0) begin errors++;
      $display("FAIL illegal_reset got state=%0d err=%b want 0/0", state, Error); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      run_instr(int'($urandom_range(0, 6)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset_mid_instr();
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL reset_mid got %0d want 0", state); end
    reset = 1'b0;
    run_instr(C_LW, 3'b010, 1'b0);
  endtask

  initial begin
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    test_reset();
    test_lw();
    test_rtype();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_random();
    test_reset_mid_instr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ucsbece154a_mc_controller.md
# ucsbece154a_mc_controller

Main control unit for the multicycle RV32I core: a Moore state machine that sequences the shared ALU, single unified memory port, instruction register and register file over 3–5 cycles per instruction. It also contains the ALU decoder and immediate-select decoder. It sits in `riscv` beside the multicycle datapath `dp` and replaces the single-cycle combinational controller.

## Interface
Parameters: none.

Ports (clock and reset first):
- `clk` input 1 — core clock; all state changes on rising edge.
- `reset` input 1 — synchronous, active-high; forces state to FETCH.
- `op` input 7 — instruction[6:0], from instruction register.
- `funct3` input 3 — instruction[14:12].
- `funct7b5` input 1 — instruction[30].
- `zero` input 1 — ALU zero flag.
- `PCWrite` output 1 — PC register enable.
- `AdrSrc` output 1 — memory address select: 0 = PC, 1 = ALUOut/Result.
- `MemWrite` output 1 — memory write enable.
- `IRWrite` output 1 — latches instruction and OldPC.
- `RegWrite` output 1 — register file write enable.
- `ResultSrc` output 2 — 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt.
- `ALUSrcA` output 2 — 00 PC, 01 OldPC, 10 rs1 data.
- `ALUSrcB` output 2 — 00 rs2 data, 01 ImmExt, 10 constant 4.
- `ALUControl` output 3 — add 000, sub 001, and 010, or 011, slt 101.
- `ImmSrc` output 3 — I 000, S 001, B 010, J 011, U 100.
- `Error` output 1 — high while in ERROR state.
- `state` output 4 — current state encoding, for debug/bench.

## Operation
- States and encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BRANCH 10, LUI 11, ERROR 15.
- Transitions:
  - FETCH→DECODE.
  - DECODE on `op`: 0000011 or 0100011 → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1101111 → JAL; 1100011 → BRANCH; 0110111 → LUI; any other value → ERROR.
  - MEMADR → MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD → MEMWB.
  - EXECUTER, EXECUTEI, JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH, LUI → FETCH.
  - ERROR is sticky until `reset`.
- Per-state controls (unlisted outputs are 0; ALUOp is internal, 2 bits):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target into ALUOut).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - LUI: ResultSrc=11, RegWrite=1.
  - ERROR: all enables 0, Error=1.
- PCWrite = PCUpdate | (Branch & taken).
  - taken = `zero` when funct3=000 (beq), ~`zero` when funct3=001 (bne).
  - Any other funct3 in BRANCH: not taken.
- ALU decoder:
  - ALUOp 00 → add; 01 → sub; 11 → add.
  - ALUOp 10, by funct3:
    - 000: sub if op[5] & funct7b5, else add.
    - 010: slt.
    - 110: or.
    - 111: and.
    - any other funct3: add.
- ImmSrc decodes from `op` in every state:
  - lw/addi-class → I.
  - sw → S.
  - branch → B.
  - jal → J.
  - lui → U.
  - otherwise 000.

## Timing
- State register only; all outputs are combinational from state, `op`, `funct3`, `funct7b5`, `zero`. No output registers.
- Reset: on the rising edge with `reset`=1, state becomes FETCH regardless of current state, including mid-instruction and ERROR. While in FETCH, IRWrite=1 and PCWrite=1, so the bench holds `reset` for ≥2 edges; the datapath PC reset wins.
- Cycles per instruction: lw 5; sw, R-type, I-type, jal 4; beq/bne, lui 3.
- MemWrite and RegWrite are each high for exactly one cycle per instruction that uses them; never both in the same cycle.
- The `zero` sample for a branch is taken in the BRANCH cycle only.

## Test plan
- Reset: `reset`=1 for 2 edges from arbitrary state → `state`=0, IRWrite=1, PCWrite=1, ALUSrcB=10, Error=0.
- lw (op=0000011): `state` sequence 0,1,2,3,4,0. RegWrite=1 only in state 4 with ResultSrc=01. AdrSrc=1 only in state 3.
- R-type sub (op=0110011, funct3=000, funct7b5=1): states 0,1,6,7,0. ALUControl=001 in state 6. With funct7b5=0, ALUControl=000. Same op with funct3=111 → ALUControl=010.
- Branch: op=1100011, funct3=000, zero=1 → PCWrite=1 in state 10, 3-cycle return to 0. zero=0 → PCWrite=0. funct3=001 inverts both results.
- sw then lui back-to-back: states 0,1,2,5,0,1,11,0. MemWrite only in state 5. In state 11, RegWrite=1 with ResultSrc=11 and ImmSrc=100.
- Illegal op=0000000: after DECODE, `state`=15 and Error=1, held for 10 cycles. Asserting `reset` returns `state` to 0 on the next edge.
